// File: rtl/nanov_shift_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode helper
// for the bit-serial shift sequencer.
package nanov_shift_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // True for the three opcodes the shifter implements.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/nanov_shift_seq_if.sv
// Request / bit-stream / result handshake bundle of the shift sequencer.
// master = decode/writeback side, slave = sequencer.
interface nanov_shift_seq_if;
  logic        start_valid;
  logic        start_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [4:0]  b;
  logic        bit_out;
  logic        bit_valid;
  logic [4:0]  bit_idx;
  logic [31:0] result;
  logic        result_err;
  logic        result_valid;
  logic        result_ready;

  modport master (
    output start_valid, op, a, b, result_ready,
    input  start_ready, bit_out, bit_valid, bit_idx, result, result_err, result_valid
  );

  modport slave (
    input  start_valid, op, a, b, result_ready,
    output start_ready, bit_out, bit_valid, bit_idx, result, result_err, result_valid
  );
endinterface

// File: rtl/nanov_shift_seq_shift.sv
// Bit-serial shifter: returns bit 'counter' of the shifted value of 'a'
// for the given opcode and shift amount. Purely combinational.
module nanoV_shift
  import nanov_shift_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  counter,
  input  logic [31:0] a,
  input  logic [4:0]  b,
  output logic        d
);

  logic [5:0] src_right;
  logic [4:0] src_left;

  // Select the source bit of 'a' that lands at position 'counter'.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case/if tree leaves it unassigned (that would infer a latch).
    d         = 1'b0;
    src_right = {1'b0, counter} + {1'b0, b};
    src_left  = counter - b;
    case (op)
      OP_SLL: begin
        if (counter >= b) d = a[src_left];
      end
      OP_SRL, OP_SRA: begin
        if (!src_right[5])     d = a[src_right[4:0]];
        else if (op == OP_SRA) d = a[31];
      end
      default: d = 1'b0;
    endcase
  end

endmodule

// File: rtl/nanov_shift_seq.sv
// Sequencer for the bit-serial shifter: accepts one shift request, walks the
// bit counter 0..31 streaming result bits LSB-first, assembles the 32-bit
// result and holds it on a valid/ready handshake.
module nanov_shift_seq
  import nanov_shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  nanov_shift_seq_if.slave   bus
);

  state_t      state, state_next;
  logic [4:0]  counter;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [4:0]  b_q;
  logic [31:0] result_q;
  logic        err_q;
  logic        shift_bit;
  logic        accept;
  logic        start_ready, bit_valid, result_valid;

  nanoV_shift u_shift (
    .op      (op_q),
    .counter (counter),
    .a       (a_q),
    .b       (b_q),
    .d       (shift_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next   = state;
    start_ready  = 1'b0;
    bit_valid    = 1'b0;
    result_valid = 1'b0;
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (bus.start_valid) state_next = is_shift_op(bus.op) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        bit_valid = 1'b1;
        if (counter == 5'd31) state_next = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (bus.result_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = (state == S_IDLE) && bus.start_valid;

  // Operand latches, bit counter and result shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      op_q     <= bus.op;
      a_q      <= bus.a;
      b_q      <= bus.b;
      counter  <= '0;
      result_q <= '0;
      err_q    <= !is_shift_op(bus.op);
    end else if (state == S_RUN) begin
      // Bits arrive LSB-first, so after 32 steps bit 0 sits at result[0].
      result_q <= {shift_bit, result_q[31:1]};
      counter  <= counter + 5'd1;
    end
  end

  assign bus.start_ready  = start_ready;
  assign bus.bit_valid    = bit_valid;
  assign bus.result_valid = result_valid;
  assign bus.bit_out      = shift_bit;
  assign bus.bit_idx      = counter;
  assign bus.result       = result_q;
  assign bus.result_err   = err_q;

endmodule

// File: tb/tb_nanov_shift_seq.sv
// Self-checking bench for nanov_shift_seq: directed cases plus random
// op/a/b triples checked against a word-level shift model.
module tb_nanov_shift_seq;

  localparam logic [3:0] T_SLL = 4'b0001;
  localparam logic [3:0] T_SRL = 4'b0101;
  localparam logic [3:0] T_SRA = 4'b1101;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  nanov_shift_seq_if bus();

  nanov_shift_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic legal_op(input logic [3:0] op);
    return (op == T_SLL) || (op == T_SRL) || (op == T_SRA);
  endfunction

  // Word-level reference: the whole shift at once, using language operators.
  function automatic logic [31:0] ref_shift(input logic [3:0] op, input logic [31:0] a,
                                            input logic [4:0] b);
    case (op)
      T_SLL:   return a << b;
      T_SRL:   return a >> b;
      T_SRA:   return $unsigned($signed(a) >>> b);
      default: return 32'h0;
    endcase
  endfunction

  task automatic scramble();
    bus.op = 4'($urandom);
    bus.a  = $urandom;
    bus.b  = 5'($urandom);
  endtask

  // Present a request while IDLE; returns one cycle after the accept edge.
  task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [4:0] b);
    check("start_ready_idle", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    cycle();
    bus.start_valid = 1'b0;
    scramble();
  endtask

  // Check the bit stream (legal ops) and the presented result.
  task automatic stream_and_result(input logic [3:0] op, input logic [31:0] exp_r,
                                   input logic exp_err);
    if (legal_op(op)) begin
      for (int k = 0; k < 32; k++) begin
        check("stream", {23'd0, bus.bit_valid, bus.result_valid, bus.start_ready,
                         bus.bit_idx, bus.bit_out},
                        {23'd0, 1'b1, 1'b0, 1'b0, 5'(k), exp_r[k]});
        scramble();
        cycle();
      end
    end
    check("result_valid", 32'(bus.result_valid), 32'd1);
    check("result", bus.result, exp_r);
    check("result_err", 32'(bus.result_err), 32'(exp_err));
    check("done_flags", {30'd0, bus.bit_valid, bus.start_ready}, 32'd0);
  endtask

  // Hold result_ready low for 'hold' cycles, then complete the handshake.
  task automatic handshake(input int hold, input logic [31:0] exp_r);
    for (int i = 0; i < hold; i++) begin
      check("hold_result", bus.result, exp_r);
      check("hold_flags", {30'd0, bus.result_valid, bus.start_ready}, 32'd2);
      cycle();
    end
    bus.result_ready = 1'b1;
    check("hs_valid", 32'(bus.result_valid), 32'd1);
    cycle();
    bus.result_ready = 1'b0;
    check("after_hs", {30'd0, bus.result_valid, bus.start_ready}, 32'd1);
  endtask

  task automatic txn(input logic [3:0] op, input logic [31:0] a, input logic [4:0] b,
                     input logic [31:0] exp_r, input int hold);
    accept(op, a, b);
    stream_and_result(op, exp_r, !legal_op(op));
    handshake(hold, exp_r);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [4:0]  r_b;

    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b0;
    bus.op = '0;
    bus.a  = '0;
    bus.b  = '0;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;

    check("rst_result", bus.result, 32'h0);
    check("rst_flags", {27'd0, bus.result_err, bus.result_valid, bus.bit_valid,
                        bus.start_ready, 1'b0}, 32'h2);
    check("rst_bit_idx", 32'(bus.bit_idx), 32'd0);

    // Illegal opcode first, then legal ones must clear the error flag.
    txn(4'b0011, 32'hDEAD_BEEF, 5'd3, 32'h0, 0);
    txn(T_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 0);
    txn(T_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 0);
    txn(T_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 0);
    txn(T_SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
    txn(T_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
    txn(T_SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);

    // Result held for 10 cycles with a second request pending throughout.
    accept(T_SRA, 32'h8123_4567, 5'd8);
    stream_and_result(T_SRA, 32'hFF81_2345, 1'b0);
    bus.start_valid = 1'b1;
    bus.op = T_SLL;
    bus.a  = 32'h0000_00F0;
    bus.b  = 5'd4;
    handshake(10, 32'hFF81_2345);
    cycle();
    bus.start_valid = 1'b0;
    scramble();
    stream_and_result(T_SLL, 32'h0000_0F00, 1'b0);
    handshake(0, 32'h0000_0F00);

    // Reset mid-RUN at bit_idx 12.
    accept(T_SRL, 32'hCAFE_F00D, 5'd5);
    repeat (12) cycle();
    check("pre_rst_idx", 32'(bus.bit_idx), 32'd12);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_result", bus.result, 32'h0);
    check("mid_rst_flags", {28'd0, bus.result_err, bus.result_valid, bus.bit_valid,
                            bus.start_ready}, 32'h1);
    check("mid_rst_idx", 32'(bus.bit_idx), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("post_rst_idle", {30'd0, bus.result_valid, bus.start_ready}, 32'd1);
      cycle();
    end
    txn(T_SRL, 32'hCAFE_F00D, 5'd5, 32'h0657_F780, 0);

    // Random triples, mostly legal, with random result back-pressure.
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: r_op = T_SLL;
        3, 4, 5: r_op = T_SRL;
        6, 7, 8: r_op = T_SRA;
        default: r_op = 4'($urandom);
      endcase
      r_a = $urandom;
      r_b = 5'($urandom);
      txn(r_op, r_a, r_b, ref_shift(r_op, r_a, r_b), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
